wb_divider_master: RTL
======================

Name: wb_divider_master

Overview:
- Wishbone initiator that drives the serial divider's CSR slave on behalf of a simple valid/ready request port.
- Per request: write DIVIDEND and DIVISOR, write START, poll FINI, read QUOTIENT and REMAINDER, then return results on a valid/ready response port.
- Used as a hardware sequencer/self-test so the divider can be exercised without the management core.

Parameters:
- WBW, 32, Wishbone data/address width.
- XLEN, 32, operand/result width (must equal WBW).
- BASE_ADR, 32'h3000_0000, divider CSR base address.
- ACK_TIMEOUT, 16, max cycles stb may be held without ack.
- POLL_LIMIT, 64, max FINI reads returning 0 before giving up.
- SETTLE, 2, idle cycles between START ack and first FINI read.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- dividend_i  in  XLEN  dividend, captured on acceptance
- divisor_i  in  XLEN  divisor, captured on acceptance
- rsp_valid_o  out  1  response valid, held until rsp_ready_i
- rsp_ready_i  in  1  response consumed
- quotient_o  out  XLEN  QUOTIENT read value
- remainder_o  out  XLEN  REMAINDER read value
- rsp_err_o  out  1  1 = timeout or rejected divisor
- busy_o  out  1  high in any state but IDLE
- wbm_cyc_o  out  1  WB cycle
- wbm_stb_o  out  1  WB strobe
- wbm_we_o  out  1  WB write enable
- wbm_sel_o  out  WBW/8  byte selects, always all ones during a cycle
- wbm_adr_o  out  WBW  WB address
- wbm_dat_o  out  WBW  WB write data (0 on reads)
- wbm_ack_i  in  1  WB acknowledge
- wbm_dat_i  in  WBW  WB read data

Behaviour:
- Clock, reset: one clock, clk_i; reset_i is synchronous and active-high. All outputs and the FSM are registered.
- Reset values:
  - All wbm_* outputs are 0.
  - rsp_valid_o, rsp_err_o and busy_o are 0.
  - quotient_o and remainder_o are 0.
  - req_ready_o is 1 and the FSM is in IDLE.
  - Reset asserted mid-operation aborts at the next edge: cyc/stb fall, no response is produced, and the FSM goes to IDLE.
- FSM states: IDLE, WR_DVD, WR_DVS, WR_START, SETTLE_W, RD_FINI, RD_QUO, RD_REM, RESP.
- IDLE:
  - req_ready_o is high only in IDLE.
  - On acceptance, latch the operands.
  - If divisor_i[XLEN-1:1]==0 (divisor 0 or 1, which the divider never finishes), go directly to RESP next cycle with err=1 and quotient/remainder=0. No bus cycle is issued.
  - Otherwise go to WR_DVD.
- Bus transaction rule:
  - Drive cyc, stb, we, adr, dat and sel=all ones, and hold them stable until wbm_ack_i is sampled high.
  - The cycle after ack, cyc/stb are low for exactly one gap cycle; the next transaction starts after the gap. The slave does not support back-to-back cycles.
  - With a 1-cycle-ack slave, each transaction therefore occupies 3 cycles.
  - Read data is captured in the ack cycle.
- Transaction addresses and data, in order:
  - WR_DVD: BASE+0x00, data = dividend.
  - WR_DVS: BASE+0x04, data = divisor.
  - WR_START: BASE+0x18, data = 0.
  - SETTLE_W: SETTLE idle cycles, bus low.
  - RD_FINI: read BASE+0x14. If bit0=1, go to RD_QUO. Otherwise increment the poll counter, take the gap cycle, and reread.
  - RD_QUO: read BASE+0x08 into quotient_o.
  - RD_REM: read BASE+0x0C into remainder_o.
  - Then RESP with err=0.
- Ack timeout:
  - A per-transaction counter starts at stb assertion.
  - If ACK_TIMEOUT cycles elapse without ack, drop cyc/stb and go to RESP with err=1.
  - quotient/remainder keep the values captured so far (0 if none).
  - An ack arriving in the same cycle the limit is reached counts as success.
- Poll limit: after POLL_LIMIT consecutive FINI reads returning 0, go to RESP with err=1.
- RESP:
  - rsp_valid_o is high; quotient_o, remainder_o and rsp_err_o are stable until rsp_ready_i.
  - On handshake, go to IDLE; req_ready_o rises the following cycle, so a new request is not accepted in the handshake cycle.
- Counters:
  - Counters are sized ≥ clog2(limit+1).
  - Counters saturate and never wrap.
  - Counters clear on entering each state that uses them.

Test Plan:
- Test 1, normal divide:
  - Stimulus: dividend=0x0000_0100, divisor=4, against the divider slave.
  - Bus writes: 0x3000_0000←0x100, 0x3000_0004←4, 0x3000_0018←0.
  - Then FINI polls until 1, then reads at 0x3000_0008/0x3000_000C.
  - Response: quotient_o=0x40, rsp_err_o=0.
- Test 2, rejected divisor: divisor=1 (and separately 0) → zero WB cycles; rsp_valid_o asserts the cycle after acceptance with rsp_err_o=1, quotient_o=0.
- Test 3, ack timeout: slave model never acks → cyc/stb drop exactly ACK_TIMEOUT=16 cycles after the first stb; rsp_err_o=1.
- Test 4, poll limit: model returns FINI=0 forever → exactly 64 reads to 0x3000_0014, then rsp_err_o=1; no QUOTIENT read.
- Test 5, response backpressure: rsp_ready_i held low 10 cycles → rsp_valid_o, quotient_o and rsp_err_o stable, req_ready_o=0 throughout; handshake then req_ready_o=1 one cycle later.
- Test 6, reset mid-poll: reset_i pulsed during RD_FINI with stb high → next cycle all wbm_* outputs are 0 and rsp_valid_o=0; after release req_ready_o=1 and a new request completes normally.

Source files
------------

// File: rtl/wb_divider_master.sv
// Wishbone initiator that runs one divide on the serial divider CSR block per
// valid/ready request and returns quotient, remainder and an error flag.
module wb_divider_master #(
  parameter int             WBW         = 32,
  parameter int             XLEN        = 32,
  parameter logic [WBW-1:0] BASE_ADR    = 32'h3000_0000,
  parameter int             ACK_TIMEOUT = 16,
  parameter int             POLL_LIMIT  = 64,
  parameter int             SETTLE      = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  quotient_o,
  output logic [XLEN-1:0]  remainder_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WBW/8-1:0] wbm_sel_o,
  output logic [WBW-1:0]   wbm_adr_o,
  output logic [WBW-1:0]   wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WBW-1:0]   wbm_dat_i
);

  typedef enum logic [3:0] {
    IDLE, WR_DVD, WR_DVS, WR_START, SETTLE_W, RD_FINI, RD_QUO, RD_REM, RESP
  } state_t;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_LIMIT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_busy;
  logic [XLEN-1:0]     r_dividend;
  logic [XLEN-1:0]     r_divisor;
  logic [XLEN-1:0]     r_quotient;
  logic [XLEN-1:0]     r_remainder;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [WBW/8-1:0]    r_sel;
  logic [WBW-1:0]      r_adr;
  logic [WBW-1:0]      r_dat;
  logic [TW-1:0]       r_tmo;
  logic [PW-1:0]       r_poll;
  logic [SW-1:0]       r_settle;

  logic [WBW-1:0]      w_adr;
  logic [WBW-1:0]      w_dat;
  logic                w_we;

  // Address/data of the transaction the current state launches; SETTLE_W
  // launches the first FINI read directly so the settle time includes the gap.
  always_comb begin
    w_adr = BASE_ADR;
    w_dat = '0;
    w_we  = 1'b0;
    case (r_state)
      WR_DVD:   begin w_adr = BASE_ADR + WBW'(8'h00); w_dat = r_dividend; w_we = 1'b1; end
      WR_DVS:   begin w_adr = BASE_ADR + WBW'(8'h04); w_dat = r_divisor;  w_we = 1'b1; end
      WR_START: begin w_adr = BASE_ADR + WBW'(8'h18); w_we = 1'b1; end
      SETTLE_W: w_adr = BASE_ADR + WBW'(8'h14);
      RD_FINI:  w_adr = BASE_ADR + WBW'(8'h14);
      RD_QUO:   w_adr = BASE_ADR + WBW'(8'h08);
      RD_REM:   w_adr = BASE_ADR + WBW'(8'h0C);
      default:  w_adr = BASE_ADR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_tmo       <= '0;
      r_poll      <= '0;
      r_settle    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_dividend  <= dividend_i;
            r_divisor   <= divisor_i;
            r_quotient  <= '0;
            r_remainder <= '0;
            // Divisors 0 and 1 never finish on the divider, so refuse them.
            if (divisor_i[XLEN-1:1] == '0) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_rsp_err <= 1'b0;
              r_state   <= WR_DVD;
            end
          end
        end

        SETTLE_W: begin
          if (r_settle == SETTLE_LAST) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= w_we;
            r_sel   <= '1;
            r_adr   <= w_adr;
            r_dat   <= w_dat;
            r_tmo   <= '0;
            r_poll  <= '0;
            r_state <= RD_FINI;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          if (!r_stb) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= w_we;
            r_sel <= '1;
            r_adr <= w_adr;
            r_dat <= w_dat;
            r_tmo <= '0;
          end else if (wbm_ack_i) begin
            // Dropping the strobe here yields the mandatory one-cycle gap.
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= '0;
            r_adr <= '0;
            r_dat <= '0;
            case (r_state)
              WR_DVD:   r_state <= WR_DVS;
              WR_DVS:   r_state <= WR_START;
              WR_START: begin
                r_settle <= '0;
                r_state  <= SETTLE_W;
              end
              RD_FINI: begin
                if (wbm_dat_i[0]) begin
                  r_state <= RD_QUO;
                end else if (r_poll == POLL_LAST) begin
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
                end else begin
                  r_poll <= r_poll + 1'b1;
                end
              end
              RD_QUO: begin
                r_quotient <= wbm_dat_i;
                r_state    <= RD_REM;
              end
              RD_REM: begin
                r_remainder <= wbm_dat_i;
                r_rsp_valid <= 1'b1;
                r_state     <= RESP;
              end
              default: r_state <= IDLE;
            endcase
          end else if (r_tmo == TMO_LAST) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = r_busy;
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_stb;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;

endmodule
